// File: rtl/oscan1_host_encoder.sv
// ---------------------------------------------------------------------------
// oscan1_host_encoder
// Host-side cJTAG OScan1 encoder. Brings the link up with an Online
// Activation Code (OAC) followed by a JScan OSCAN_ON command, then serialises
// JTAG bits as SF0 frames (TMS, TDI, TDO turnaround). A stop request sends
// OAC + JScan OSCAN_OFF and returns the link to IDLE.
//
// Ports
//   clk, rst_n             block clock (rising edge), async active-low reset
//   start, stop            single-cycle link up / link down requests
//   bit_valid, bit_ready   JTAG bit handshake (transfer when both high)
//   bit_tms, bit_tdi       TMS/TDI values of the offered bit
//   tdo_valid, tdo_data    one-cycle pulse with the captured TDO
//   tckc                   cJTAG clock to the target
//   tmsc_out, tmsc_oen     TMSC pad drive value and active-low output enable
//   tmsc_in                TMSC pad input
//   link_active, busy      OScan1 SF0 link up / sequence or bit in progress
//
// State table
//   IDLE    | link down, waiting for start
//   OAC     | 16 tckc toggles with tmsc low
//   JSCAN   | 4 command bits LSB first plus one pad bit, one per tckc cycle
//   ACTIVE  | link up, waiting for a bit or a stop
//   SF0_TMS | low phase drives TMS, ends with tckc rising
//   SF0_TDI | high phase drives TDI, ends with tckc falling
//   SF0_TDO | TMSC released for turnaround, TDO captured at window end
// ---------------------------------------------------------------------------
module oscan1_host_encoder #(
    parameter int HALF_PERIOD = 4,
    parameter int TDO_WINDOW  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    input  logic bit_valid,
    output logic bit_ready,
    input  logic bit_tms,
    input  logic bit_tdi,
    output logic tdo_valid,
    output logic tdo_data,
    output logic tckc,
    output logic tmsc_out,
    output logic tmsc_oen,
    input  logic tmsc_in,
    output logic link_active,
    output logic busy
);

    localparam int DW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam int WW = $clog2(TDO_WINDOW + 1);
    localparam logic [DW-1:0] DIV_LOAD = DW'(HALF_PERIOD - 1);
    localparam logic [DW-1:0] DIV_MID  = DW'(HALF_PERIOD / 2);
    localparam logic [WW-1:0] WIN_LOAD = WW'(TDO_WINDOW);

    typedef enum logic [2:0] {
        IDLE, OAC, JSCAN, ACTIVE, SF0_TMS, SF0_TDI, SF0_TDO
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [3:0]    tog_cnt, tog_nxt;
    logic [3:0]    bit_cnt, bit_nxt;
    logic [WW-1:0] win_cnt, win_nxt;
    logic [3:0]    cmd, cmd_nxt;
    logic          tms_q, tms_nxt, tdi_q, tdi_nxt;
    logic          stop_pend, stop_pend_nxt;
    logic          tckc_nxt, tmsc_out_nxt, tmsc_oen_nxt;
    logic          tdo_valid_nxt, tdo_data_nxt, link_nxt;
    logic          phase_end, phase_mid;

    // Divider counts down once per clk; the midpoint is HALF_PERIOD/2 cycles
    // into a phase and the terminal count is the phase boundary.
    assign phase_end = (div_cnt == '0);
    assign phase_mid = (div_cnt == DIV_MID);

    // A stop in the same cycle blocks acceptance so stop always wins.
    assign bit_ready = (state == ACTIVE) && !stop_pend && !stop;
    assign busy      = (state != IDLE) && (state != ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div_cnt     <= '0;
            tog_cnt     <= '0;
            bit_cnt     <= '0;
            win_cnt     <= '0;
            cmd         <= '0;
            tms_q       <= 1'b0;
            tdi_q       <= 1'b0;
            stop_pend   <= 1'b0;
            tckc        <= 1'b0;
            tmsc_out    <= 1'b0;
            tmsc_oen    <= 1'b0;
            tdo_valid   <= 1'b0;
            tdo_data    <= 1'b0;
            link_active <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= div_nxt;
            tog_cnt     <= tog_nxt;
            bit_cnt     <= bit_nxt;
            win_cnt     <= win_nxt;
            cmd         <= cmd_nxt;
            tms_q       <= tms_nxt;
            tdi_q       <= tdi_nxt;
            stop_pend   <= stop_pend_nxt;
            tckc        <= tckc_nxt;
            tmsc_out    <= tmsc_out_nxt;
            tmsc_oen    <= tmsc_oen_nxt;
            tdo_valid   <= tdo_valid_nxt;
            tdo_data    <= tdo_data_nxt;
            link_active <= link_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        div_nxt       = phase_end ? DIV_LOAD : div_cnt - 1'b1;
        tog_nxt       = tog_cnt;
        bit_nxt       = bit_cnt;
        win_nxt       = win_cnt;
        cmd_nxt       = cmd;
        tms_nxt       = tms_q;
        tdi_nxt       = tdi_q;
        stop_pend_nxt = stop_pend;
        tckc_nxt      = tckc;
        tmsc_out_nxt  = tmsc_out;
        tmsc_oen_nxt  = tmsc_oen;
        tdo_valid_nxt = 1'b0;
        tdo_data_nxt  = tdo_data;
        link_nxt      = link_active;

        case (state)
            IDLE: begin
                div_nxt = DIV_LOAD;
                if (start && !stop) begin
                    state_nxt = OAC;
                    cmd_nxt   = 4'h1;
                    tog_nxt   = 4'd15;
                end
            end
            ACTIVE: begin
                div_nxt = DIV_LOAD;
                if (stop || stop_pend) begin
                    state_nxt     = OAC;
                    cmd_nxt       = 4'h0;
                    tog_nxt       = 4'd15;
                    stop_pend_nxt = 1'b0;
                end else if (bit_valid) begin
                    state_nxt = SF0_TMS;
                    tms_nxt   = bit_tms;
                    tdi_nxt   = bit_tdi;
                end
            end
            OAC: begin
                if (phase_mid) tmsc_out_nxt = 1'b0;
                if (phase_end) begin
                    tckc_nxt = ~tckc;
                    if (tog_cnt == 4'd0) begin
                        state_nxt = JSCAN;
                        bit_nxt   = 4'd0;
                    end else begin
                        tog_nxt = tog_cnt - 4'd1;
                    end
                end
            end
            JSCAN: begin
                // bit_cnt == 5 marks the cycle after the 5th falling toggle.
                if (bit_cnt == 4'd5) begin
                    if (cmd == 4'h1) begin
                        state_nxt = ACTIVE;
                        link_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        link_nxt  = 1'b0;
                    end
                end else begin
                    if (phase_mid && !tckc)
                        tmsc_out_nxt = (bit_cnt < 4'd4) ? cmd[bit_cnt[1:0]] : 1'b0;
                    if (phase_end) begin
                        tckc_nxt = ~tckc;
                        if (tckc) bit_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            SF0_TMS: begin
                if (stop) stop_pend_nxt = 1'b1;
                if (phase_mid) tmsc_out_nxt = tms_q;
                if (phase_end) begin
                    tckc_nxt  = 1'b1;
                    state_nxt = SF0_TDI;
                end
            end
            SF0_TDI: begin
                if (stop) stop_pend_nxt = 1'b1;
                if (phase_mid) tmsc_out_nxt = tdi_q;
                if (phase_end) begin
                    tckc_nxt  = 1'b0;
                    state_nxt = SF0_TDO;
                    win_nxt   = WIN_LOAD;
                end
            end
            SF0_TDO: begin
                if (stop) stop_pend_nxt = 1'b1;
                if (win_cnt == '0) begin
                    tdo_valid_nxt = 1'b1;
                    tdo_data_nxt  = tmsc_in;
                    tmsc_oen_nxt  = 1'b0;
                    state_nxt     = ACTIVE;
                end else begin
                    // Release one cycle after the falling edge of tckc.
                    if (win_cnt == WIN_LOAD) tmsc_oen_nxt = 1'b1;
                    win_nxt = win_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_oscan1_host_encoder.sv
module tb_oscan1_host_encoder;

    logic clk, rst_n, start, stop, bit_valid, bit_tms, bit_tdi, tmsc_in;
    logic bit_ready, tdo_valid, tdo_data, tckc, tmsc_out, tmsc_oen;
    logic link_active, busy;

    int n_chk = 0;
    int n_fail = 0;

    logic tr_tmsc [0:17];
    logic tr_tckc [0:17];
    logic tr_oen  [0:17];
    logic tr_tdov [0:17];
    logic tr_tdod [0:17];
    logic tr_rdy  [0:17];
    logic tr_busy [0:17];

    oscan1_host_encoder #(.HALF_PERIOD(4), .TDO_WINDOW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .bit_valid(bit_valid), .bit_ready(bit_ready),
        .bit_tms(bit_tms), .bit_tdi(bit_tdi),
        .tdo_valid(tdo_valid), .tdo_data(tdo_data),
        .tckc(tckc), .tmsc_out(tmsc_out), .tmsc_oen(tmsc_oen), .tmsc_in(tmsc_in),
        .link_active(link_active), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge after the sampling edge.
    task automatic pulse(input logic s, input logic p);
        start = s;
        stop  = p;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Observes a link sequence; k=0 is the current sample point.
    task automatic watch_seq(input int max_k, output int n_tog, output logic [4:0] bits,
                             output int t_end, output int viol);
        logic pt, pm;
        int   nrise;
        bit   seen;
        n_tog = 0; bits = '0; t_end = -1; viol = 0; nrise = 0;
        seen = busy; pt = tckc; pm = tmsc_out;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            if (tckc != pt) begin
                n_tog++;
                if (tmsc_out != pm) viol++;
                if (tckc) begin
                    nrise++;
                    if (nrise >= 9 && nrise <= 13) bits[nrise-9] = tmsc_out;
                end
            end
            if (busy) seen = 1'b1;
            else if (seen && t_end < 0) t_end = k;
            pt = tckc;
            pm = tmsc_out;
        end
    endtask

    // Sends one SF0 bit from ACTIVE; optionally pulses stop so it is sampled at t=stop_at.
    // Returns at the sample point after t=17.
    task automatic send_bit(input logic tms, input logic tdi, input logic tdo, input int stop_at);
        bit_tms = tms; bit_tdi = tdi; tmsc_in = tdo; bit_valid = 1'b1;
        #1 chk("rdy_before_bit", bit_ready, 1);
        @(negedge clk);
        bit_valid = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            tr_tmsc[k] = tmsc_out; tr_tckc[k] = tckc; tr_oen[k] = tmsc_oen;
            tr_tdov[k] = tdo_valid; tr_tdod[k] = tdo_data;
            tr_rdy[k] = bit_ready; tr_busy[k] = busy;
            stop = (k + 1 == stop_at);
        end
        stop = 1'b0;
        chk("sf0_busy_t1",  tr_busy[1], 1);
        chk("sf0_tmsc_t2",  tr_tmsc[2], tms);
        chk("sf0_tckc_t3",  tr_tckc[3], 0);
        chk("sf0_tckc_t4",  tr_tckc[4], 1);
        chk("sf0_rdy_t5",   tr_rdy[5],  0);
        chk("sf0_tmsc_t5",  tr_tmsc[5], tms);
        chk("sf0_tmsc_t6",  tr_tmsc[6], tdi);
        chk("sf0_tckc_t7",  tr_tckc[7], 1);
        chk("sf0_tckc_t8",  tr_tckc[8], 0);
        chk("sf0_oen_t8",   tr_oen[8],  0);
        chk("sf0_oen_t9",   tr_oen[9],  1);
        chk("sf0_oen_t16",  tr_oen[16], 1);
        chk("sf0_oen_t17",  tr_oen[17], 0);
        chk("sf0_tdov_t16", tr_tdov[16], 0);
        chk("sf0_tdov_t17", tr_tdov[17], 1);
        chk("sf0_tdod_t17", tr_tdod[17], tdo);
        chk("sf0_rdy_t17",  tr_rdy[17], (stop_at >= 0) ? 1'b0 : 1'b1);
    endtask

    initial begin
        int n_tog, t_end, viol, np, bad;
        logic [4:0] bits;
        logic [2:0] dat;
        logic pat [0:3];
        bit any;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; bit_valid = 1'b0;
        bit_tms = 1'b0; bit_tdi = 1'b0; tmsc_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tckc", tckc, 0);
        chk("rst_tmsc_out", tmsc_out, 0);
        chk("rst_tmsc_oen", tmsc_oen, 0);
        chk("rst_bit_ready", bit_ready, 0);
        chk("rst_tdo_valid", tdo_valid, 0);
        chk("rst_tdo_data", tdo_data, 0);
        chk("rst_link", link_active, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // IDLE corners: bit_valid ignored, start+stop together ignored
        bit_valid = 1'b1;
        any = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bit_ready || busy) any = 1'b1;
        end
        bit_valid = 1'b0;
        chk("idle_bit_valid_ignored", any, 0);
        pulse(1'b1, 1'b1);
        any = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy || tckc || link_active) any = 1'b1;
        end
        chk("idle_start_stop_ignored", any, 0);

        // Link up
        pulse(1'b1, 1'b0);
        watch_seq(115, n_tog, bits, t_end, viol);
        chk("up_toggles", n_tog, 26);
        chk("up_bits", bits, 5'b00001);
        chk("up_link_cycle", t_end, 105);
        chk("up_tmsc_vs_tckc", viol, 0);
        chk("up_link_active", link_active, 1);
        chk("up_tckc_low", tckc, 0);
        chk("up_bit_ready", bit_ready, 1);

        // start while ACTIVE is ignored
        pulse(1'b1, 1'b0);
        any = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy || tckc || !link_active) any = 1'b1;
        end
        chk("active_start_ignored", any, 0);

        // Single bit
        send_bit(1'b1, 1'b0, 1'b1, -1);
        @(negedge clk);
        chk("tdo_pulse_width", tdo_valid, 0);
        chk("tdo_data_hold", tdo_data, 1);

        // Back-to-back bits with bit_valid held
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
        np = 0; bad = 0; dat = '0;
        bit_tms = 1'b0; bit_tdi = 1'b1; tmsc_in = pat[0]; bit_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (tdo_valid) begin
                if (np < 3) dat[np] = tdo_data;
                np++;
                tmsc_in = pat[(np < 3) ? np : 3];
                if (np >= 3) bit_valid = 1'b0;
            end
            if (bit_ready && busy) bad++;
        end
        bit_valid = 1'b0;
        chk("b2b_pulses", np, 3);
        chk("b2b_data", dat, 3'b101);
        chk("b2b_ready_while_busy", bad, 0);

        // stop during a bit
        send_bit(1'b0, 1'b1, 1'b1, 5);
        watch_seq(115, n_tog, bits, t_end, viol);
        chk("down_toggles", n_tog, 26);
        chk("down_bits", bits, 5'b00000);
        chk("down_tmsc_vs_tckc", viol, 0);
        chk("down_link_active", link_active, 0);
        chk("down_busy", busy, 0);
        chk("down_ready", bit_ready, 0);

        // Reset at OAC toggle 10
        pulse(1'b1, 1'b0);
        n_tog = 0;
        any = tckc;
        for (int k = 0; k < 100 && n_tog < 10; k++) begin
            @(negedge clk);
            if (tckc != any) n_tog++;
            any = tckc;
        end
        chk("rst_mid_reach_tog10", n_tog, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_tckc", tckc, 0);
        chk("rst_mid_tmsc_out", tmsc_out, 0);
        chk("rst_mid_oen", tmsc_oen, 0);
        chk("rst_mid_tdo_data", tdo_data, 0);
        chk("rst_mid_link", link_active, 0);
        chk("rst_mid_ready", bit_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        any = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy || tckc) any = 1'b1;
        end
        chk("rst_no_resume", any, 0);
        pulse(1'b1, 1'b0);
        watch_seq(115, n_tog, bits, t_end, viol);
        chk("restart_toggles", n_tog, 26);
        chk("restart_bits", bits, 5'b00001);
        chk("restart_link_cycle", t_end, 105);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
